// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver to AXI-stream beats; `I2S_RX_OVF_COUNT_EN adds ovf_count
module i2s_rx #(
    parameter int DW    = 24,
    parameter int DEPTH = 4,
    localparam int TIDW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            lrclk,
    input  logic            sdi,
    output logic [DW-1:0]   m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [TIDW-1:0] m_axis_tid,
    output logic            ovf
`ifdef I2S_RX_OVF_COUNT_EN
    ,
    output logic [15:0]     ovf_count
`endif
);

    localparam int CW = $clog2(DW);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_IDLE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sclk_prev_q, sclk_prev_d;
    logic            lrclk_prev_q, lrclk_prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic            chan_q, chan_d;
    logic [DW:0]     mem_q [DEPTH];
    logic [DW:0]     mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            sclk_rise;
    logic            lr_edge;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic [DW:0]     push_word;

    // Serial front end: detect sclk rises, track slot boundaries and shift in bits.
    always_comb begin
        sclk_prev_d  = sclk;
        lrclk_prev_d = lrclk_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        chan_d       = chan_q;
        push         = 1'b0;
        push_word    = {chan_q, shift_q[DW-2:0], sdi};
        sclk_rise    = sclk & ~sclk_prev_q;
        lr_edge      = sclk_rise & (lrclk != lrclk_prev_q);
        if (sclk_rise) begin
            lrclk_prev_d = lrclk;
            // The DW-th bit may land on the next slot's transition edge (slot width == DW).
            if (state_q == ST_SHIFT && cnt_q == CW'(DW - 1)) begin
                push = 1'b1;
            end
            if (lr_edge) begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
                shift_d = '0;
                chan_d  = lrclk;
            end else if (state_q == ST_SHIFT) begin
                shift_d = {shift_q[DW-2:0], sdi};
                if (push) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Output FIFO: accept completed words, drop on full unless a pop frees a slot.
    always_comb begin
        mem_d    = mem_q;
        pop      = (count_q != '0) & m_axis_tready;
        full     = (count_q == NW'(DEPTH));
        wr_en    = push & (~full | pop);
        ovf_d    = push & full & ~pop;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_word;
        end
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + NW'(wr_en) - NW'(pop);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_UNSYNC;
            sclk_prev_q  <= 1'b0;
            lrclk_prev_q <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            chan_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_prev_q  <= sclk_prev_d;
            lrclk_prev_q <= lrclk_prev_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            chan_q       <= chan_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = mem_q[rd_ptr_q][DW-1:0];
    assign m_axis_tid    = {{(TIDW-1){1'b0}}, mem_q[rd_ptr_q][DW]};
    assign ovf           = ovf_q;

`ifdef I2S_RX_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of dropped words.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_q && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - randomized self-checking bench for i2s_rx against a slot-level model
module tb_i2s_rx;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int MAXN  = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          sdi = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic [7:0]    tid;
    logic          ovf;
`ifdef I2S_RX_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    i2s_rx #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .sclk          (sclk),
        .lrclk         (lrclk),
        .sdi           (sdi),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tid    (tid),
        .ovf           (ovf)
`ifdef I2S_RX_OVF_COUNT_EN
        ,
        .ovf_count     (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial stream: one entry per sclk period (lrclk level, sdi level).
    bit          lr_a [MAXN];
    bit          sd_a [MAXN];
    int          len;
    logic [DW:0] exp_q [$];
    int          exp_drops;

    task automatic new_seq();
        len = 0;
        for (int i = 0; i < MAXN; i++) begin
            lr_a[i] = 1'b0;
            sd_a[i] = 1'($urandom);
        end
    endtask

    // I2S slot: word MSB one bit after the lrclk change; optional 1-fill past DW bits.
    task automatic add_slot(bit c, int s, logic [DW-1:0] w, bit fill);
        for (int k = 0; k < s; k++) begin
            lr_a[len + k] = c;
            if (k < DW)   sd_a[len + 1 + k] = w[DW-1-k];
            else if (fill) sd_a[len + 1 + k] = 1'b1;
        end
        len += s;
    endtask

    // Reference: after each lrclk change, the next DW bits form a word if they all
    // arrive no later than the following change (and within the stream).
    task automatic build_expect(int keep);
        int t [$];
        bit prev;
        logic [DW:0] w;
        prev = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        for (int i = 0; i < len; i++) begin
            if (lr_a[i] != prev) t.push_back(i);
            prev = lr_a[i];
        end
        t.push_back(len - 1);
        for (int j = 0; j < t.size() - 1; j++) begin
            if (t[j] + DW <= t[j+1]) begin
                w[DW] = lr_a[t[j]];
                for (int k = 0; k < DW; k++) w[DW-1-k] = sd_a[t[j] + 1 + k];
                if (exp_q.size() < keep) exp_q.push_back(w);
                else exp_drops++;
            end
        end
    endtask

    // sclk = clk/8; lrclk/sdi change while sclk is low.
    task automatic play(int from, int to, int watch);
        for (int i = from; i < to; i++) begin
            sclk  = 1'b0;
            lrclk = lr_a[i];
            sdi   = sd_a[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (i == watch) begin
                check("lat_before", tvalid, 0);
                @(negedge clk);
                check("lat_after", tvalid, 1);
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        sclk  = 1'b0;
        lrclk = 1'b0;
        sdi   = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    int nrx  = 0;
    int novf = 0;

    task automatic finish_test(string tag, int base_rx, int exp_beats);
        repeat (60) @(negedge clk);
        check({tag, "_beats"}, nrx - base_rx, exp_beats);
        check({tag, "_left"}, exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard beats, count ovf pulses, check stall stability.
    logic        hold_v = 1'b0;
    logic [31:0] hold_w;
    always @(negedge clk) begin
        if (rst) begin
            logic [DW:0] w;
            if (ovf) novf++;
            if (hold_v) begin
                check("hold_valid", tvalid, 1);
                check("hold_data", {tid, tdata}, hold_w);
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("tdata", tdata, w[DW-1:0]);
                    check("tid", tid, {7'b0, w[DW]});
                end
                nrx++;
            end
            hold_v = tvalid && !tready;
            hold_w = {tid, tdata};
        end else begin
            hold_v = 1'b0;
        end
    end

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #2 tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int base;
        int obase;
        bit c;

        @(negedge clk);
        do_reset();
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tid", tid, 0);
        check("rst_ovf", ovf, 0);

        // Basic L/R frame with 24-bit slots and first-beat latency.
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        add_slot(1'b0, 24, 24'hA5A5A5, 1'b0);
        add_slot(1'b1, 24, 24'h123456, 1'b0);
        add_slot(1'b0, 6, '0, 1'b0);
        build_expect(100);
        check("t1_model_words", exp_q.size(), 2);
        base = nrx;
        play(0, len, 28);
        finish_test("basic", base, 2);

        // Stream starts mid left slot.
        do_reset();
        new_seq();
        add_slot(1'b0, 13, 24'($urandom), 1'b0);
        add_slot(1'b1, 24, 24'($urandom), 1'b0);
        add_slot(1'b0, 24, 24'($urandom), 1'b0);
        add_slot(1'b1, 24, 24'($urandom), 1'b0);
        add_slot(1'b0, 6, '0, 1'b0);
        build_expect(100);
        base = nrx;
        play(0, len, -1);
        finish_test("midslot", base, 3);

        // 32-bit slots padded with ones.
        do_reset();
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        for (int i = 0; i < 4; i++) add_slot(1'(i), 32, 24'($urandom), 1'b1);
        add_slot(1'b0, 6, '0, 1'b0);
        build_expect(100);
        base = nrx;
        play(0, len, -1);
        finish_test("slot32", base, 4);

        // Short slot of 10 bits is discarded without ovf.
        do_reset();
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        add_slot(1'b0, 10, 24'($urandom), 1'b0);
        add_slot(1'b1, 24, 24'($urandom), 1'b0);
        add_slot(1'b0, 24, 24'($urandom), 1'b0);
        add_slot(1'b1, 6, '0, 1'b0);
        build_expect(100);
        base  = nrx;
        obase = novf;
        play(0, len, -1);
        finish_test("short", base, 2);
        check("short_no_ovf", novf - obase, 0);

        // Overflow: six words with tready low, DEPTH kept.
        do_reset();
        tready = 1'b0;
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        for (int i = 0; i < 6; i++) add_slot(1'(i), 24, 24'($urandom), 1'b0);
        add_slot(1'b0, 6, '0, 1'b0);
        build_expect(DEPTH);
        check("ovf_model_drops", exp_drops, 2);
        base  = nrx;
        obase = novf;
        play(0, len, -1);
        repeat (10) @(negedge clk);
        check("ovf_pulses", novf - obase, exp_drops);
        check("ovf_full_valid", tvalid, 1);
        check("ovf_head", tdata, exp_q[0][DW-1:0]);
`ifdef I2S_RX_OVF_COUNT_EN
        check("ovf_count", ovf_count, 2);
`endif
        tready = 1'b1;
        finish_test("ovf_drain", base, DEPTH);

        // Reset in the middle of a word.
        do_reset();
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        add_slot(1'b0, 24, 24'($urandom), 1'b0);
        play(0, 16, -1);
        do_reset();
        check("midrst_tvalid", tvalid, 0);
        check("midrst_tdata", tdata, 0);
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        add_slot(1'b0, 24, 24'($urandom), 1'b0);
        add_slot(1'b1, 24, 24'($urandom), 1'b0);
        add_slot(1'b0, 6, '0, 1'b0);
        build_expect(100);
        base = nrx;
        play(0, len, -1);
        finish_test("midrst", base, 2);

        // Random slot widths, words, padding and backpressure.
        do_reset();
        rand_rdy = 1'b1;
        new_seq();
        add_slot(1'b1, 4, '0, 1'b0);
        c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            add_slot(c, $urandom_range(10, 34), 24'($urandom), 1'($urandom));
            c = ~c;
        end
        add_slot(c, 6, '0, 1'b0);
        build_expect(100);
        base  = nrx;
        obase = novf;
        play(0, len, -1);
        finish_test("random", base, exp_q.size() + nrx - base);
        check("random_all_seen", exp_q.size(), 0);
        check("random_no_ovf", novf - obase, 0);
        rand_rdy = 1'b0;
        @(negedge clk);
        tready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver: oversamples `sclk`, `lrclk` and `sdi` in the `clk` (mclk) domain.
- Deserialises standard I2S frames: MSB first, one-bit delay after the `lrclk` transition, data sampled on `sclk` rising edge.
- Emits one AXI-stream beat per channel word, with `tid` marking left or right.
- Sits between an external ADC/codec serial port and the stream fabric. It is the companion of the I2S transmitter block.

Parameters:
- DW, 24, word width in bits captured per channel slot.
- DEPTH, 4, output buffer depth in words; power of two, >= 2.
- TIDW, 8, `m_axis_tid` width (fixed, not user-overridable).

Ports:
- clk  in  1  system clock (mclk); must be at least 4x `sclk`.
- rst  in  1  synchronous, active-low reset.
- sclk  in  1  I2S bit clock, sync'd to `clk` externally.
- lrclk  in  1  I2S word select: 0 = left, 1 = right.
- sdi  in  1  I2S serial data.
- m_axis_tdata  out  DW  received word.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  downstream accept.
- m_axis_tid  out  TIDW  channel: 0 = L, 1 = R; upper bits 0.
- ovf  out  1  one-cycle pulse when a completed word is dropped (buffer full).

Behaviour:
- Reset (`rst` = 0 at a `clk` edge):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tid`=0, `ovf`=0.
  - Buffer emptied, bit counter=0, shift register=0.
  - `sclk_prev`=0, `lrclk_prev`=0.
  - State -> UNSYNC.
- Edge detect: `sclk_rise` = `sclk` && !`sclk_prev`, where `sclk_prev` is registered every `clk`. `lrclk` and `sdi` are sampled only in `sclk_rise` cycles.
- `lrclk` transition: in an `sclk_rise` cycle where sampled `lrclk` != `lrclk_prev`. `lrclk_prev` updates only on `sclk_rise`.
- State UNSYNC: ignore all data. On the first `lrclk` transition -> SHIFT, with bit counter=0 and channel=new `lrclk`.
- State SHIFT: on each `sclk_rise` after the transition edge, shift `sdi` into the LSB of the shift register and increment the bit counter.
  - The bit sampled on the transition edge itself is the previous slot's trailing bit. It is discarded.
- Word complete: when the counter reaches DW, push {`lrclk`, shift register} into the buffer, then state -> IDLE_SLOT.
  - The word is visible on `m_axis_tvalid` the `clk` cycle after the capturing `sclk_rise` if the buffer was empty.
- State IDLE_SLOT: ignore bits until the next `lrclk` transition. The transition edge -> SHIFT, with counter=0 and channel updated.
- Short slot: an `lrclk` transition while in SHIFT with counter < DW means the partial word is discarded, with no `ovf`. Restart SHIFT for the new channel.
- Buffer: FIFO of DEPTH entries, first-word fall-through.
  - Output is a registered head entry.
  - A pop occurs on `m_axis_tvalid` && `m_axis_tready`.
  - `m_axis_tdata` and `m_axis_tid` are held stable while `tvalid`=1 && `tready`=0.
- Full: a push while full with no simultaneous pop drops the new word, pulses `ovf`=1 for one cycle, and leaves contents unchanged.
  - Push and pop in the same cycle while full are both accepted, with no drop.
- Ordering: words leave in capture order. L and R alternate unless words were dropped or discarded.
- Reset mid-frame: any partial word is lost. Resync waits for the next `lrclk` transition.

Optional Feature:
- Macro `I2S_RX_OVF_COUNT_EN`.
- Defined: adds output port `ovf_count` (16 bits) that increments on each `ovf` pulse. It saturates at 0xFFFF and is cleared by reset.
- Undefined: the port and counter are absent. `ovf` behaviour is unchanged.

Test Plan:
- Reset, then `sclk`=`clk`/8 with DW=24, L word 0xA5A5A5 and R word 0x123456 (I2S format), `tready`=1 -> beats (0xA5A5A5, tid 0) then (0x123456, tid 1). The first beat appears 1 `clk` after the 24th post-transition `sclk` rise.
- Start stream mid-slot after reset -> the partial slot is ignored, and the first emitted beat is the first complete slot after an `lrclk` edge.
- 32-bit slots (8 extra bits of 0xFF after each word) with DW=24 -> tdata equals the first 24 bits only, and the extra bits are ignored.
- `tready`=0 for 6 words with DEPTH=4 -> 4 words held, `ovf` pulses twice, and draining gives the first 4 words in order.
- `lrclk` toggles after only 10 bits -> that word is discarded with no `ovf`, and the following full slot is received correctly.
- Assert `rst`=0 mid-word, then release -> `tvalid`=0 and the buffer is empty. The next output is a full word from a post-reset `lrclk` transition.
